// File: rtl/seg7_pkg.sv
// Shared constants and decode classification for the seven-segment scan driver.
// All segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        DecDigit,
        DecBlank,
        DecDash
    } dec_kind_e;

    // Blanking wins over everything; codes above 9 render as a dash.
    function automatic dec_kind_e classify_bcd(input logic [3:0] bcd, input logic blank);
        if (blank) begin
            return DecBlank;
        end
        if (bcd > 4'd9) begin
            return DecDash;
        end
        return DecDigit;
    endfunction

endpackage

// File: rtl/seg7_scan_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder with a blank override.
// Invalid codes 10-15 produce a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    dec_kind_e kind;

    assign kind = classify_bcd(bcd, blank);

    always_comb begin
        seg = SEG_BLANK;
        unique case (kind)
            DecBlank: seg = SEG_BLANK;
            DecDash:  seg = SEG_DASH;
            default: begin
                case (bcd)
                    4'd0:    seg = SEG_0;
                    4'd1:    seg = SEG_1;
                    4'd2:    seg = SEG_2;
                    4'd3:    seg = SEG_3;
                    4'd4:    seg = SEG_4;
                    4'd5:    seg = SEG_5;
                    4'd6:    seg = SEG_6;
                    4'd7:    seg = SEG_7;
                    4'd8:    seg = SEG_8;
                    4'd9:    seg = SEG_9;
                    default: seg = SEG_DASH;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: slot-latched inputs, guard gap,
// leading-zero suppression and per-digit blink. State advances on the falling clock edge.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50_000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic [3:0]  blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned ScanW  = $clog2(DIGIT_CYCLES);
    localparam int unsigned BlinkW = $clog2(BLINK_CYCLES);

    localparam logic [ScanW-1:0]  SCAN_LAST  = ScanW'(DIGIT_CYCLES - 1);
    localparam logic [ScanW-1:0]  GUARD_END  = ScanW'(GUARD_CYCLES);
    localparam logic [BlinkW-1:0] BLINK_LAST = BlinkW'(BLINK_CYCLES - 1);

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;

    // slot_valid_q forces a latch on the first edge after reset.
    logic              slot_valid_q;
    logic [15:0]       slot_bcd_q;
    logic [3:0]        slot_dp_q;
    logic              slot_lz_q;
    logic [3:0]        slot_blink_q;
    logic              slot_load;

    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic              scan_wrap;
    logic              blink_wrap;
    logic [15:0]       bcd_shifted;
    logic [3:0]        digit_nib;
    logic              lz_hit;
    logic              blank_digit;
    logic              in_guard;
    logic              blink_off;
    logic [6:0]        dec_seg;

    assign scan_wrap  = (scan_cnt_q == SCAN_LAST);
    assign blink_wrap = (blink_cnt_q == BLINK_LAST);
    assign slot_load  = scan_wrap || !slot_valid_q;

    always_comb begin
        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
        digit_idx_d   = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BlinkW'(1);
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    // Suppression looks only at the latched slot, so a digit never flickers mid-slot.
    always_comb begin
        lz_hit = 1'b0;
        unique case (digit_idx_q)
            2'd3:    lz_hit = (slot_bcd_q[15:12] == 4'd0);
            2'd2:    lz_hit = (slot_bcd_q[15:8] == 8'd0);
            2'd1:    lz_hit = (slot_bcd_q[15:4] == 12'd0);
            default: lz_hit = 1'b0;
        endcase
    end

    assign bcd_shifted = slot_bcd_q >> {digit_idx_q, 2'b00};
    assign digit_nib   = bcd_shifted[3:0];
    assign blank_digit = slot_lz_q && lz_hit;

    bcd_to_seg7 u_decode (
        .bcd   (digit_nib),
        .blank (blank_digit),
        .seg   (dec_seg)
    );

    assign in_guard  = (scan_cnt_q < GUARD_END);
    assign blink_off = blink_phase_q && slot_blink_q[digit_idx_q];

    always_comb begin
        an_d  = ANODE_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!in_guard && !blink_off) begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = dec_seg;
            dp_d  = ~slot_dp_q[digit_idx_q];
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_bcd_q    <= 16'd0;
            slot_dp_q     <= 4'd0;
            slot_lz_q     <= 1'b0;
            slot_blink_q  <= 4'd0;
            an_q          <= ANODE_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (slot_load) begin
                slot_valid_q <= 1'b1;
                slot_bcd_q   <= bcd_in;
                slot_dp_q    <= dp_in;
                slot_lz_q    <= blank_lz;
                slot_blink_q <= blink_en;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: directed scenarios plus randomized inputs,
// every cycle compared against a cycle-count based reference model.
module tb_seg7_scan;

    localparam int unsigned DC = 8;
    localparam int unsigned GC = 2;
    localparam int unsigned BC = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_en = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan #(
        .DIGIT_CYCLES (DC),
        .GUARD_CYCLES (GC),
        .BLINK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Reference model: c counts non-reset falling edges since the last reset.
    int unsigned m_cyc = 0;
    bit          m_seen_reset = 1'b0;
    bit          m_slot_ok = 1'b0;
    int unsigned m_bcd = 0;
    logic [3:0]  m_dp = 4'h0;
    bit          m_lz = 1'b0;
    logic [3:0]  m_blink = 4'h0;
    logic [11:0] exp_out = 12'hFFF;

    function automatic logic [11:0] model_out(input int unsigned c);
        int unsigned scan, d, ph, nib, upper;
        logic [3:0] a;
        logic [6:0] s;
        scan  = c % DC;
        d     = (c / DC) % 4;
        ph    = (c / BC) % 2;
        if (scan < GC || (ph == 1 && m_blink[d])) begin
            return 12'hFFF;
        end
        nib   = (m_bcd >> (4 * d)) % 16;
        upper = m_bcd >> (4 * d);
        a = 4'hF;
        a[d] = 1'b0;
        s = (m_lz && d > 0 && upper == 0) ? 7'h7F : ref_seg(int'(nib));
        return {a, s, ~m_dp[d]};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            exp_out      = 12'hFFF;
            m_cyc        = 0;
            m_slot_ok    = 1'b0;
            m_seen_reset = 1'b1;
        end else begin
            exp_out = model_out(m_cyc);
            if (!m_slot_ok || (m_cyc % DC) == DC - 1) begin
                m_bcd     = int'(bcd_in);
                m_dp      = dp_in;
                m_lz      = blank_lz;
                m_blink   = blink_en;
                m_slot_ok = 1'b1;
            end
            m_cyc++;
        end
    end

    always @(posedge clk) begin
        if (m_seen_reset) begin
            check_val("model", {4'h0, an, seg, dp}, {4'h0, exp_out});
        end
    end

    // Directed scenarios: cur is the model cycle whose result is visible now.
    int cur = 0;

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        reset = 1'b0;
        @(posedge clk);
        cur = 0;
    endtask

    task automatic at_cyc(input int target);
        if (target > cur) begin
            repeat (target - cur) @(posedge clk);
        end
        cur = target;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                              input logic e_dp);
        check_val(tag, {4'h0, an, seg, dp}, {4'h0, e_an, e_seg, e_dp});
    endtask

    initial begin
        // 1: basic scan order and guard gap
        bcd_in = 16'h1234;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        expect_out("t1_reset", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        cur = 0;
        expect_out("t1_guard0", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(1);  expect_out("t1_guard1", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(2);  expect_out("t1_d0", 4'b1110, 7'b0011001, 1'b1);
        at_cyc(8);  expect_out("t1_guard_s1", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(10); expect_out("t1_d1", 4'b1101, 7'b0110000, 1'b1);
        at_cyc(18); expect_out("t1_d2", 4'b1011, 7'b0100100, 1'b1);
        at_cyc(26); expect_out("t1_d3", 4'b0111, 7'b1111001, 1'b1);

        // 2: leading-zero suppression with dp passthrough
        bcd_in = 16'h0009; blank_lz = 1'b1; dp_in = 4'b0010;
        do_reset();
        at_cyc(2);  expect_out("t2_d0", 4'b1110, 7'b0010000, 1'b1);
        at_cyc(10); expect_out("t2_d1", 4'b1101, 7'b1111111, 1'b0);
        at_cyc(18); expect_out("t2_d2", 4'b1011, 7'b1111111, 1'b1);
        at_cyc(26); expect_out("t2_d3", 4'b0111, 7'b1111111, 1'b1);
        blank_lz = 1'b0;
        at_cyc(31);
        at_cyc(34); expect_out("t2_nolz_d0", 4'b1110, 7'b0010000, 1'b1);
        at_cyc(42); expect_out("t2_nolz_d1", 4'b1101, 7'b1000000, 1'b0);
        at_cyc(58); expect_out("t2_nolz_d3", 4'b0111, 7'b1000000, 1'b1);

        // 3: invalid code shows dash and counts as nonzero
        bcd_in = 16'h00F0; blank_lz = 1'b1; dp_in = 4'b0000;
        do_reset();
        at_cyc(2);  expect_out("t3_d0", 4'b1110, 7'b1000000, 1'b1);
        at_cyc(10); expect_out("t3_dash", 4'b1101, 7'b0111111, 1'b1);
        at_cyc(18); expect_out("t3_d2", 4'b1011, 7'b1111111, 1'b1);
        at_cyc(26); expect_out("t3_d3", 4'b0111, 7'b1111111, 1'b1);

        // 4: blink on digit 0 only
        bcd_in = 16'h1234; blank_lz = 1'b0; blink_en = 4'b0001;
        do_reset();
        at_cyc(2);   expect_out("t4_on", 4'b1110, 7'b0011001, 1'b1);
        at_cyc(66);  expect_out("t4_off", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(71);  expect_out("t4_off_end", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(74);  expect_out("t4_other", 4'b1101, 7'b0110000, 1'b1);
        at_cyc(130); expect_out("t4_on_again", 4'b1110, 7'b0011001, 1'b1);

        // 5: mid-slot input change does not tear the digit
        bcd_in = 16'h1111; blink_en = 4'b0000;
        do_reset();
        at_cyc(3);
        bcd_in = 16'h2222;
        at_cyc(6);  expect_out("t5_hold", 4'b1110, 7'b1111001, 1'b1);
        at_cyc(10); expect_out("t5_next", 4'b1101, 7'b0100100, 1'b1);

        // 6: one-cycle reset mid digit-2 slot while blink phase is 1
        bcd_in = 16'h1234;
        do_reset();
        at_cyc(84); expect_out("t6_pre", 4'b1011, 7'b0100100, 1'b1);
        blink_en = 4'b1111;
        reset = 1'b1;
        @(posedge clk);
        expect_out("t6_reset", 4'b1111, 7'b1111111, 1'b1);
        reset = 1'b0;
        cur = -1;
        at_cyc(0); expect_out("t6_g0", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(1); expect_out("t6_g1", 4'b1111, 7'b1111111, 1'b1);
        at_cyc(2); expect_out("t6_d0", 4'b1110, 7'b0011001, 1'b1);

        // Randomized stimulus, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 6) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                                       : 4'($urandom_range(0, 15));
                end
                dp_in    = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
                blink_en = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
